pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the pipelined MIPS datapath. It replaces bare enable-registers between stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake, an optional skid slot, a synchronous flush that injects a bubble, and a saturating stall-cycle counter. Each instance holds one stage's full payload (instruction, PC, control bits, operands) as a single WIDTH-bit vector.

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry,
// synchronous flush to a bubble, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}},
    parameter int unsigned       SKID      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      stall_cnt,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and out_valid/out_data are registered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [15:0]        stall_q;
    logic               in_fire;
    logic               out_fire;

    assign out_valid   = (state_q != ST_EMPTY);
    assign out_data    = main_q;
    assign stall_cnt   = stall_q;
    assign dbg_state_o = state_q;
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;

    // With a skid entry, FULL can always absorb one more beat, so in_ready
    // depends on state only; without it, FULL accepts only while draining.
    always_comb begin
        in_ready = 1'b1;
        case (state_q)
            ST_EMPTY: in_ready = 1'b1;
            ST_FULL:  in_ready = (SKID != 0) ? 1'b1 : out_ready;
            ST_SKID:  in_ready = 1'b0;
            default:  in_ready = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_fire && in_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    main_d  = NOP_VALUE;
                    state_d = ST_EMPTY;
                end else if (in_fire && (SKID != 0)) begin
                    skid_d  = in_data;
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: begin
                main_d  = NOP_VALUE;
                state_d = ST_EMPTY;
            end
        endcase
        // Flush wins over every transfer; the skid contents become unreachable.
        if (flush) begin
            main_d  = NOP_VALUE;
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    a_bubble_is_nop: assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> (out_data == NOP_VALUE));
    a_skid_reachable: assert property (@(posedge clk) disable iff (rst)
        (SKID == 0) |-> (state_q != ST_SKID));
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, each checked
// every cycle against an occupancy-queue model of the stage.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done_b   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SKID=1
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;
    logic [1:0]  a_dbg;

    // Instance B: SKID=0
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [15:0] b_stall_cnt;
    logic [1:0]  b_dbg;

    pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(1)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall_cnt), .dbg_state_o(a_dbg)
    );

    pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(0)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt), .dbg_state_o(b_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic v, input logic [31:0] d, input logic ordy,
                           input logic fl, input logic r);
        a_in_valid  = v;
        a_in_data   = d;
        a_out_ready = ordy;
        a_flush     = fl;
        a_rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] d, input logic ordy,
                           input logic fl, input logic r);
        b_in_valid  = v;
        b_in_data   = d;
        b_out_ready = ordy;
        b_flush     = fl;
        b_rst       = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference models / scoreboards ----------------
    // The model is just the ordered list of entries held by the stage plus a
    // stall counter; outputs are derived from how many entries are held.
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    int          stall_m_a = 0;
    int          stall_m_b = 0;

    always @(negedge clk) begin
        logic        ev, er, fin, fout;
        logic [31:0] ed;
        ev = (exp_q_a.size() > 0);
        ed = ev ? exp_q_a[0] : NOP;
        er = (exp_q_a.size() < 2);
        chk("a_out_valid", 32'(a_out_valid), 32'(ev));
        chk("a_out_data",  a_out_data, ed);
        chk("a_in_ready",  32'(a_in_ready), 32'(er));
        chk("a_stall_cnt", 32'(a_stall_cnt), 32'(stall_m_a));
        chk("a_state",     32'(a_dbg), 32'(exp_q_a.size()));
        fin  = a_in_valid && er;
        fout = ev && a_out_ready;
        if (a_rst) begin
            exp_q_a.delete();
            stall_m_a = 0;
        end else begin
            if (ev && !a_out_ready && stall_m_a < 65535) stall_m_a++;
            if (a_flush) exp_q_a.delete();
            else begin
                if (fout) void'(exp_q_a.pop_front());
                if (fin) exp_q_a.push_back(a_in_data);
            end
        end
    end

    always @(negedge clk) begin
        logic        ev, er, fin, fout;
        logic [31:0] ed;
        ev = (exp_q_b.size() > 0);
        ed = ev ? exp_q_b[0] : NOP;
        er = (exp_q_b.size() == 0) || b_out_ready;
        chk("b_out_valid", 32'(b_out_valid), 32'(ev));
        chk("b_out_data",  b_out_data, ed);
        chk("b_in_ready",  32'(b_in_ready), 32'(er));
        chk("b_stall_cnt", 32'(b_stall_cnt), 32'(stall_m_b));
        chk("b_state",     32'(b_dbg), 32'(exp_q_b.size()));
        fin  = b_in_valid && er;
        fout = ev && b_out_ready;
        if (b_rst) begin
            exp_q_b.delete();
            stall_m_b = 0;
        end else begin
            if (ev && !b_out_ready && stall_m_b < 65535) stall_m_b++;
            if (b_flush) exp_q_b.delete();
            else begin
                if (fout) void'(exp_q_b.pop_front());
                if (fin) exp_q_b.push_back(b_in_data);
            end
        end
    end

    // ---------------- stimulus, instance B (SKID=0) ----------------
    initial begin
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) drive_b(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive_b(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        chk("b_ready_comb_low", 32'(b_in_ready), 32'd0);
        b_out_ready = 1'b1;
        #1;
        chk("b_ready_comb_high", 32'(b_in_ready), 32'd1);
        for (int i = 1; i <= 8; i++) drive_b(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++)
            drive_b($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        drive_b(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        done_b = 1'b1;
    end

    // ---------------- stimulus, instance A (SKID=1) ----------------
    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        repeat (2) drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("a_reset_valid", 32'(a_out_valid), 32'd0);
        chk("a_reset_ready", 32'(a_in_ready), 32'd1);

        // streaming
        for (int i = 0; i < 5; i++) drive_a(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("a_stream_stall", 32'(a_stall_cnt), 32'd0);

        // skid fill and drain
        drive_a(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("a_skid_ready", 32'(a_in_ready), 32'd0);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("a_skid_stall", 32'(a_stall_cnt), 32'd1);

        // flush from the skid state, with a competing input
        drive_a(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
        chk("a_flush_valid", 32'(a_out_valid), 32'd0);
        chk("a_flush_data",  a_out_data, NOP);
        chk("a_flush_ready", 32'(a_in_ready), 32'd1);
        chk("a_flush_stall", 32'(a_stall_cnt), 32'd2);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            drive_a($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);

        // reset in the middle of a stream
        for (int i = 0; i < 8; i++) drive_a(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, i == 3);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // counter saturation
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        drive_a(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        repeat (65540) drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("a_sat_cnt",   32'(a_stall_cnt), 32'h0000_FFFF);
        chk("a_sat_valid", 32'(a_out_valid), 32'd1);
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("a_sat_hold",  32'(a_stall_cnt), 32'h0000_FFFF);
        drive_a(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("a_rst_cnt",   32'(a_stall_cnt), 32'd0);
        chk("a_rst_valid", 32'(a_out_valid), 32'd0);
        drive_a(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        wait (done_b);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
